// File: rtl/seg_scan_driver.sv
// Multiplexed common-anode 7-segment driver: shadows a packed BCD value and scans
// one digit per refresh window, with a dark first cycle per window and leading-zero blanking.
module seg_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  iClk,
    input  logic                  iRst_n,
    input  logic [4*DIGITS-1:0]   iBCD,
    input  logic [DIGITS-1:0]     iDp,
    input  logic                  iLoad,
    input  logic                  iBlankEn,
    output logic [6:0]            oSeg,
    output logic                  oDp,
    output logic [DIGITS-1:0]     oAn
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;
    logic [DIGITS-1:0]   dp_q, dp_d;
    logic [6:0]          seg_q, seg_d;
    logic                dpo_q, dpo_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic [3:0]          digit [DIGITS];
    logic [DIGITS:0]     zero_from;
    logic [DIGITS-1:0]   blank;
    logic [3:0]          nib;
    logic [6:0]          dec;

    // zero_from[k] is set when shadow digit k and every digit above it are zero
    assign zero_from[DIGITS] = 1'b1;
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign digit[gi]     = bcd_q[4*gi +: 4];
            assign zero_from[gi] = (digit[gi] == 4'd0) && zero_from[gi+1];
            if (gi == 0) begin : g_lsd
                assign blank[gi] = 1'b0;
            end else begin : g_upper
                assign blank[gi] = iBlankEn && zero_from[gi];
            end
        end
    endgenerate

    always_comb begin
        bcd_d = iLoad ? iBCD : bcd_q;
        dp_d  = iLoad ? iDp  : dp_q;

        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_d = cnt_q + 1'b1;
            idx_d = idx_q;
        end

        nib = digit[idx_q];
        case (nib)
            4'd0:    dec = 7'b0000001;
            4'd1:    dec = 7'b1001111;
            4'd2:    dec = 7'b0010010;
            4'd3:    dec = 7'b0000110;
            4'd4:    dec = 7'b1001100;
            4'd5:    dec = 7'b0100100;
            4'd6:    dec = 7'b0100000;
            4'd7:    dec = 7'b0001111;
            4'd8:    dec = 7'b0000000;
            4'd9:    dec = 7'b0000100;
            default: dec = 7'b1111111;
        endcase

        seg_d = blank[idx_q] ? 7'b1111111 : dec;
        dpo_d = ~dp_q[idx_q];
        // First cycle of each window keeps all anodes off to avoid ghosting
        an_d  = (cnt_q == '0) ? '1 : ~(DIGITS'(1) << idx_q);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            cnt_q <= '0;
            idx_q <= '0;
            bcd_q <= '0;
            dp_q  <= '0;
            seg_q <= 7'b1111111;
            dpo_q <= 1'b1;
            an_q  <= '1;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            bcd_q <= bcd_d;
            dp_q  <= dp_d;
            seg_q <= seg_d;
            dpo_q <= dpo_d;
            an_q  <= an_d;
        end
    end

    assign oSeg = seg_q;
    assign oDp  = dpo_q;
    assign oAn  = an_q;

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed, parametrised 7-segment display driver for the frequency counter's readout. It latches a packed multi-digit BCD value and scans the digits one at a time through shared segment lines. It adds a per-digit decimal point, optional leading-zero blanking and an inter-digit dark cycle that suppresses ghosting. It sits between the counter's BCD conversion stage and the board's common-anode display pins.

## Interface
- DIGITS, 4, number of digits scanned; legal 1..8
- REFRESH_DIV, 50000, clock cycles per digit window; legal ≥ 2
- iClk  in  1  system clock; all logic on rising edge
- iRst_n  in  1  asynchronous, active-low reset
- iBCD  in  4*DIGITS  packed BCD value; digit k = iBCD[4k+3:4k], digit 0 least significant
- iDp  in  DIGITS  decimal point request per digit, active high
- iLoad  in  1  one-cycle strobe; captures iBCD/iDp into the shadow registers
- iBlankEn  in  1  enables leading-zero blanking; sampled live
- oSeg  out  7  segments {a,b,c,d,e,f,g}, MSB = a, active low
- oDp  out  1  decimal point, active low
- oAn  out  DIGITS  digit enables, active low, at most one low at a time

## Operation
- Shadow registers: bcd_q and dp_q load from iBCD/iDp on any cycle with iLoad=1 and hold otherwise. Display uses only the shadow registers, so a mid-scan update never tears a digit.
- Refresh counter cnt, width $clog2(REFRESH_DIV):
  - counts 0..REFRESH_DIV-1, then wraps to 0;
  - at wrap, digit index idx advances 0→1→…→DIGITS-1→0.
  - With DIGITS=1, idx stays 0.
- Dark cycle: while cnt==0, the next output register value has oAn all ones. Segment and decimal-point values are still computed normally.
- Decode of the selected nibble n = bcd_q[idx] (active low):
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100
  - 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100
  - 10..15 = 1111111 (blank)
- Leading-zero blanking: digit k≥1 is blanked when iBlankEn=1, bcd_q[k]==0, and every shadow digit above k is also 0.
  - A blanked digit drives oSeg=1111111.
  - Digit 0 is never blanked.
  - oDp is not affected by blanking.
- oDp = ~dp_q[idx].
- oAn = ~(1<<idx) outside the dark cycle.
- Reset mid-operation clears immediately and asynchronously: cnt=0, idx=0, bcd_q=0, dp_q=0, all outputs at reset values.

## Timing
- Reset values: oSeg=1111111, oDp=1, oAn=all ones, cnt=0, idx=0, bcd_q=0, dp_q=0.
- Output latency: all outputs are registered, so outputs in cycle t+1 reflect idx, cnt and shadow state in cycle t.
- Digit window: REFRESH_DIV cycles per digit, the first of them dark. Full scan period = DIGITS*REFRESH_DIV cycles.
- Load latency: an iLoad at edge t updates the shadow at t. The lit digit shows the new value on outputs from edge t+1.
- Simultaneous iLoad and counter wrap: both take effect in the same cycle. The new idx is decoded from the new shadow value.
- iLoad held high: the shadow tracks the inputs every cycle.
- iBlankEn change: takes effect on outputs the next cycle.
- After reset release: the first edge gives a dark cycle for digit 0. Digit 0 is lit from the second edge.

## Test plan
- Reset: assert iRst_n=0 mid-scan with iLoad pulsing.
  - Outputs go to 1111111 / 1 / all ones without waiting for a clock edge.
  - After release (DIGITS=4, REFRESH_DIV=4): oAn=1111 for one cycle, then 1110 for three cycles.
- Decode sweep: DIGITS=1, load each of 0..15, iBlankEn=0.
  - oSeg matches the table for 0..9.
  - oSeg = 1111111 for 10..15.
- Scan order: DIGITS=4, REFRESH_DIV=4, load 0x1234.
  - oAn repeats the sequence 1111,1110×3, 1111,1101×3, 1111,1011×3, 1111,0111×3.
  - Lit segments show 4, 3, 2, 1 respectively.
- Blanking: load 0x0042 with iBlankEn=1.
  - Digits 3 and 2 show 1111111; digit 1 shows 1001100; digit 0 shows 0010010.
  - Load 0x0000: only digit 0 shows 0000001.
  - Set iBlankEn=0: 0x0042 shows 0000001 on digits 3 and 2.
- Decimal point: load iDp=0010 with value 0x0000 and iBlankEn=1.
  - oDp=0 only while digit 1 is lit, even though digit 1's segments are blanked.
- Load mid-window and at wrap: pulse iLoad with 0x5678 in the middle of digit 2's window, then again coincident with a wrap.
  - Segments change exactly one cycle after each load.
  - The digit entered at the wrap is decoded from the new value.
